fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the 5-stage RV32 core. It replaces the single-register fetch/decode hold with a DEPTH-entry prefetch queue of {pc, instr} pairs. It drives the synchronous imemory (1-cycle read latency) and presents instructions to decode over a valid/ready handshake. It supports branch/jump redirect with flush and discard of in-flight fetches.

---
 rtl/fetch_queue_unit_pkg.sv | 14 +
 rtl/fetch_queue_unit_sync_fifo.sv | 50 +++++
 rtl/fetch_queue_unit.sv | 81 ++++++++
 tb/tb_fetch_queue_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DATAW_DEF     = 32;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0100_0000;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES   = 4;

    typedef struct packed {
        logic [DATAW_DEF-1:0] pc;
        logic [DATAW_DEF-1:0] instr;
    } fetch_entry;

endpackage

// File: rtl/fetch_queue_unit_sync_fifo.sv
// Power-of-two circular FIFO with flush; head is read straight from registered storage.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [PTRW:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != (PTRW+1)'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTRW+1)'(do_push) - (PTRW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: PC generation and credit-based issue into imemory, prefetch queue towards decode.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int          DATAW     = DATAW_DEF,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          DEPTH     = 4,
    parameter int          PTRW      = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [DATAW-1:0] imem_addr,
    output logic             imem_enable,
    input  logic [DATAW-1:0] imem_data,
    input  logic             redirect,
    input  logic [DATAW-1:0] redirect_pc,
    output logic             instr_valid,
    output logic [DATAW-1:0] instr,
    output logic [DATAW-1:0] instr_pc,
    input  logic             instr_ready,
    output logic [PTRW:0]    count
);

    logic [DATAW-1:0]   fetch_pc_r;
    logic [DATAW-1:0]   inflight_pc_r;
    logic               inflight_r;
    logic               issue;
    logic               push;
    logic               pop;
    logic [2*DATAW-1:0] head;

    // Credit counts the in-flight response as occupied so a push always has room.
    always_comb begin
        issue = !reset && !redirect &&
                (({1'b0, count} + (PTRW+2)'(inflight_r)) < (PTRW+2)'(DEPTH));
        push  = inflight_r && !redirect;
        pop   = instr_valid && instr_ready;
    end

    assign imem_enable = issue;
    assign imem_addr   = fetch_pc_r;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_r    <= DATAW'(BASE_ADDR);
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (redirect) begin
            fetch_pc_r <= {redirect_pc[DATAW-1:2], 2'b00};
            inflight_r <= 1'b0;
        end else if (issue) begin
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_pc_r;
            fetch_pc_r    <= fetch_pc_r + DATAW'(INSTR_BYTES);
        end else begin
            inflight_r <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (2*DATAW),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({inflight_pc_r, imem_data}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        instr_valid = (count != '0);
        instr_pc    = instr_valid ? head[2*DATAW-1:DATAW] : '0;
        instr       = instr_valid ? head[DATAW-1:0]       : '0;
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit against a queue-based reference model.
module tb_fetch_queue_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_enable;
    logic [31:0] imem_data = '0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] mq[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;

    fetch_queue_unit #(
        .DATAW     (32),
        .BASE_ADDR (32'h0100_0000),
        .DEPTH     (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_enable (imem_enable),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Synchronous imemory: one-cycle read latency.
    always @(posedge clock) begin
        if (imem_enable) imem_data <= mem_word(imem_addr);
    end

    task automatic model_reset();
        mq.delete();
        m_infl    = 1'b0;
        m_infl_pc = '0;
        m_fpc     = 32'h0100_0000;
    endtask

    task automatic run_cycle(input logic rdy, input logic red, input logic [31:0] rpc);
        logic        exp_en;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int unsigned occ;
        instr_ready = rdy;
        redirect    = red;
        redirect_pc = rpc;
        @(negedge clock);
        occ       = mq.size();
        exp_en    = !red && ((occ + 32'(m_infl)) < 4);
        exp_valid = (occ != 0);
        exp_pc    = exp_valid ? mq[0] : 32'h0;
        exp_instr = exp_valid ? mem_word(mq[0]) : 32'h0;
        checks++;
        if (imem_enable !== exp_en) begin
            errors++;
            $display("FAIL imem_enable cyc=%0d got=%b exp=%b", cyc, imem_enable, exp_en);
        end
        checks++;
        if (imem_addr !== m_fpc) begin
            errors++;
            $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fpc);
        end
        checks++;
        if (instr_valid !== exp_valid) begin
            errors++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, exp_valid);
        end
        checks++;
        if (instr_pc !== exp_pc) begin
            errors++;
            $display("FAIL instr_pc cyc=%0d got=%h exp=%h", cyc, instr_pc, exp_pc);
        end
        checks++;
        if (instr !== exp_instr) begin
            errors++;
            $display("FAIL instr cyc=%0d got=%h exp=%h", cyc, instr, exp_instr);
        end
        checks++;
        if (count !== 3'(occ)) begin
            errors++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count, occ);
        end
        @(posedge clock);
        if (red) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = {rpc[31:2], 2'b00};
        end else begin
            if (exp_valid && rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (exp_en) begin
                m_infl    = 1'b1;
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (imem_enable !== 1'b0 || imem_addr !== 32'h0100_0000 || instr_valid !== 1'b0 ||
            instr !== 32'h0 || instr_pc !== 32'h0 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s got en=%b addr=%h v=%b instr=%h pc=%h cnt=%0d exp en=0 addr=01000000 v=0 instr=0 pc=0 cnt=0",
                     tag, imem_enable, imem_addr, instr_valid, instr, instr_pc, count);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_stream();
        repeat (20) run_cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_stall();
        repeat (10) run_cycle(1'b0, 1'b0, '0);
        checks++;
        if (count !== 3'd4 || imem_enable !== 1'b0) begin
            errors++;
            $display("FAIL stall_full got cnt=%0d en=%b exp cnt=4 en=0", count, imem_enable);
        end
        repeat (12) run_cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect();
        int n = 0;
        while (!(mq.size() == 3 && m_infl) && n < 20) begin
            run_cycle(1'b0, 1'b0, '0);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL redirect_setup got occ=%0d infl=%b exp occ=3 infl=1", mq.size(), m_infl);
        end
        run_cycle(1'b0, 1'b1, 32'h0100_0100);
        checks++;
        if (count !== 3'd0 || instr_valid !== 1'b0 || imem_addr !== 32'h0100_0100) begin
            errors++;
            $display("FAIL redirect_flush got cnt=%0d v=%b addr=%h exp cnt=0 v=0 addr=01000100",
                     count, instr_valid, imem_addr);
        end
        repeat (8) run_cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect_pop();
        repeat (4) run_cycle(1'b1, 1'b0, '0);
        run_cycle(1'b1, 1'b1, 32'h0100_0102);
        checks++;
        if (count !== 3'd0 || imem_addr !== 32'h0100_0100) begin
            errors++;
            $display("FAIL redirect_pop got cnt=%0d addr=%h exp cnt=0 addr=01000100", count, imem_addr);
        end
        repeat (8) run_cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        run_cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (6) begin
            if (instr_valid) seen.push_back(instr_pc);
            run_cycle(1'b1, 1'b0, '0);
        end
        checks++;
        if (seen.size() < 3 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0 || seen[2] !== 32'h4) begin
            errors++;
            $display("FAIL wrap_seq got n=%0d first=%h exp FFFFFFFC,00000000,00000004",
                     seen.size(), (seen.size() > 0) ? seen[0] : 32'h0);
        end
    endtask

    task automatic test_async_reset();
        repeat (6) run_cycle(1'b1, 1'b0, '0);
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) run_cycle(1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        logic        rdy;
        logic        red;
        logic [31:0] rpc;
        repeat (400) begin
            rdy = ($urandom_range(0, 3) != 0);
            red = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? $urandom : (32'h0100_0000 + $urandom_range(0, 255));
            run_cycle(rdy, red, rpc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
